// File: rtl/mem_pkg.sv
// mem_pkg: shared state type, fill constant and byte-replication helper
package mem_pkg;

    typedef enum logic {INIT, READY} state_e;

    localparam logic [7:0] INIT_BYTE_DEF = 8'hFF;

    // widest data bus the fill helper can build; callers keep the low DATA_W bits
    localparam int MAX_W = 1024;

    function automatic logic [MAX_W-1:0] rep_byte(logic [7:0] b, int nbytes);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W / 8; i++)
            if (i < nbytes) r[8*i +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/param_mem_ctrl_if.sv
// param_mem_ctrl_if: wen/ren word bus between a requester and the memory
interface param_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic                wen;
    logic                ren;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                err;
    logic                ready;

    modport master (output wen, ren, addr, wdata, wstrb, input rdata, rvalid, err, ready);
    modport slave  (input wen, ren, addr, wdata, wstrb, output rdata, rvalid, err, ready);
endinterface

// File: rtl/mem_init_seq.sv
// mem_init_seq: walks every word after reset or clr, then opens the bus
module mem_init_seq
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_d;

    // state and fill pointer; async reset always restarts the fill at word 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            init_addr <= '0;
        end else begin
            state_q   <= state_d;
            init_addr <= addr_d;
        end
    end

    // clr restarts the fill from any state; the last fill write also flips to READY
    always_comb begin
        state_d = state_q;
        addr_d  = init_addr;
        if (clr) begin
            state_d = INIT;
            addr_d  = '0;
        end else if (state_q == INIT) begin
            addr_d = init_addr + ADDR_W'(1);
            if (init_addr == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
                addr_d  = '0;
            end
        end
    end

    assign init_we = state_q == INIT;
    assign ready   = state_q == READY;

endmodule

// File: rtl/param_mem_ctrl.sv
// param_mem_ctrl: byte-strobed word memory with registered read and range check
module param_mem_ctrl
    import mem_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 4,
    parameter int         ADDR_W    = $clog2(DEPTH),
    parameter logic [7:0] INIT_BYTE = INIT_BYTE_DEF
) (
    input logic             clk,
    input logic             rst,
    input logic             clr,
    param_mem_ctrl_if.slave bus
);

    localparam int                 NB     = DATA_W / 8;
    localparam logic [MAX_W-1:0]  FILL_W = rep_byte(INIT_BYTE, NB);
    localparam logic [DATA_W-1:0] FILL   = FILL_W[DATA_W-1:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic              init_we, ready, accept, in_range, wr_oor;
    logic [ADDR_W-1:0] init_addr;

    mem_init_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .init_we  (init_we),
        .init_addr(init_addr),
        .ready    (ready)
    );

    // clr in the same cycle wins over any bus access
    assign accept    = ready && !clr;
    assign in_range  = int'(bus.addr) < DEPTH;
    assign bus.ready = ready;

    // storage: the fill sequencer owns the array until ready, then strobed bus writes
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= FILL;
        else if (accept && bus.wen && in_range)
            for (int i = 0; i < NB; i++)
                if (bus.wstrb[i]) mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
    end

    // read-first data path; write range errors are reported one cycle after the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            wr_oor     <= 1'b0;
        end else begin
            bus.rvalid <= accept && bus.ren;
            if (accept && bus.ren) bus.rdata <= in_range ? mem[bus.addr] : '0;
            wr_oor  <= accept && bus.wen && !in_range;
            bus.err <= accept && ((bus.ren && !in_range) || wr_oor);
        end
    end

endmodule

// File: tb/tb_param_mem_ctrl.sv
// tb_param_mem_ctrl: directed vectors on an 8x4 and a 32x5 memory instance
module tb_param_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    param_mem_ctrl_if #(.DATA_W(8),  .ADDR_W(2)) b4 ();
    param_mem_ctrl_if #(.DATA_W(32), .ADDR_W(3)) b5 ();

    param_mem_ctrl #(.DATA_W(8),  .DEPTH(4)) d4 (.clk(clk), .rst(rst), .clr(clr), .bus(b4));
    param_mem_ctrl #(.DATA_W(32), .DEPTH(5)) d5 (.clk(clk), .rst(rst), .clr(clr), .bus(b5));

    typedef struct {
        logic        w;
        logic        r;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        rv;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic w, logic r, logic [2:0] a, logic [31:0] d, logic [3:0] s,
                                logic rv, logic [31:0] rd, logic er);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d; v.s = s; v.rv = rv; v.rd = rd; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic op4(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
        b4.wen = w; b4.ren = r; b4.addr = a; b4.wdata = d; b4.wstrb = 1'b1;
        @(posedge clk); #1;
        b4.wen = 1'b0; b4.ren = 1'b0;
    endtask

    task automatic rd4(input logic [1:0] a, input logic [7:0] exp, input string name);
        op4(1'b0, 1'b1, a, 8'h00);
        chk({name, " rvalid"}, b4.rvalid, 1);
        chk({name, " rdata"}, b4.rdata, exp);
    endtask

    task automatic ready_ramp(input string name);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s ready k%0d", name, k), b4.ready, k == 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; clr = 1'b0;
        b4.wen = 0; b4.ren = 0; b4.addr = '0; b4.wdata = '0; b4.wstrb = '0;
        b5.wen = 0; b5.ren = 0; b5.addr = '0; b5.wdata = '0; b5.wstrb = '0;
        #3;
        chk("rst ready", b4.ready, 0);
        chk("rst rvalid", b4.rvalid, 0);
        chk("rst rdata", b4.rdata, 0);
        chk("rst err", b4.err, 0);
        chk("rst ready5", b5.ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("init ready4 k%0d", k), b4.ready, k >= 4);
            chk($sformatf("init ready5 k%0d", k), b5.ready, k >= 5);
        end
        for (int a = 0; a < 4; a++) rd4(2'(a), 8'hFF, $sformatf("fill a%0d", a));
        @(posedge clk); #1;
        chk("idle rvalid", b4.rvalid, 0);
        chk("idle rdata hold", b4.rdata, 8'hFF);

        op4(1'b1, 1'b1, 2'd1, 8'h3C);
        chk("rw same rvalid", b4.rvalid, 1);
        chk("rw same rdata", b4.rdata, 8'hFF);
        rd4(2'd1, 8'h3C, "rw after");

        tv.push_back(mk(0, 1, 0, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0));
        tv.push_back(mk(1, 0, 2, 32'hA1B2C3D4, 4'hF, 0, 32'hFFFFFFFF, 0));
        tv.push_back(mk(1, 0, 2, 32'h00000055, 4'h1, 0, 32'hFFFFFFFF, 0));
        tv.push_back(mk(0, 1, 2, 32'h0,        4'h0, 1, 32'hA1B2C355, 0));
        tv.push_back(mk(1, 0, 4, 32'h12345678, 4'hC, 0, 32'hA1B2C355, 0));
        tv.push_back(mk(0, 1, 4, 32'h0,        4'h0, 1, 32'h1234FFFF, 0));
        tv.push_back(mk(1, 0, 3, 32'h0,        4'h0, 0, 32'h1234FFFF, 0));
        tv.push_back(mk(0, 1, 3, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0));
        tv.push_back(mk(0, 1, 6, 32'h0,        4'h0, 1, 32'h00000000, 1));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 32'h00000000, 0));
        tv.push_back(mk(1, 0, 6, 32'h00000077, 4'hF, 0, 32'h00000000, 0));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 32'h00000000, 1));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 32'h00000000, 0));
        tv.push_back(mk(0, 1, 5, 32'h0,        4'h0, 1, 32'h00000000, 1));
        tv.push_back(mk(0, 1, 0, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0));
        tv.push_back(mk(0, 1, 1, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0));
        tv.push_back(mk(0, 1, 2, 32'h0,        4'h0, 1, 32'hA1B2C355, 0));
        tv.push_back(mk(0, 1, 3, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0));
        tv.push_back(mk(0, 1, 4, 32'h0,        4'h0, 1, 32'h1234FFFF, 0));
        foreach (tv[i]) begin
            b5.wen = tv[i].w; b5.ren = tv[i].r; b5.addr = tv[i].a;
            b5.wdata = tv[i].d; b5.wstrb = tv[i].s;
            @(posedge clk); #1;
            b5.wen = 1'b0; b5.ren = 1'b0;
            chk($sformatf("v%0d rvalid", i), b5.rvalid, tv[i].rv);
            chk($sformatf("v%0d rdata", i), b5.rdata, tv[i].rd);
            chk($sformatf("v%0d err", i), b5.err, tv[i].er);
            chk($sformatf("v%0d ready", i), b5.ready, 1);
        end

        op4(1'b1, 1'b0, 2'd3, 8'h12);
        rd4(2'd3, 8'h12, "pre clr");
        b4.wen = 1'b1; b4.addr = 2'd0; b4.wdata = 8'h55; b4.wstrb = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; b4.wen = 1'b0;
        chk("clr ready", b4.ready, 0);
        chk("clr rvalid", b4.rvalid, 0);
        chk("clr err", b4.err, 0);
        ready_ramp("clr");
        for (int a = 0; a < 4; a++) rd4(2'(a), 8'hFF, $sformatf("clr fill a%0d", a));

        op4(1'b1, 1'b0, 2'd2, 8'h5A);
        rd4(2'd2, 8'h5A, "pre rst");
        #2 rst = 1'b0;
        #1;
        chk("async rst rvalid", b4.rvalid, 0);
        chk("async rst rdata", b4.rdata, 0);
        chk("async rst ready", b4.ready, 0);
        chk("async rst err", b4.err, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midinit rst ready", b4.ready, 0);
        chk("midinit rst rvalid", b4.rvalid, 0);
        @(posedge clk); #1 rst = 1'b1;
        ready_ramp("reinit");
        rd4(2'd2, 8'hFF, "reinit a2");
        rd4(2'd0, 8'hFF, "reinit a0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
